// File: rtl/delay_buffer_if.sv
// Stream bundle between a sample producer, the delay buffer and the
// downstream butterfly stage: input handshake, output pair handshake,
// flush request and priming status.
interface delay_buffer_if #(
    parameter int width_p = 16
);
    logic               flush_i;
    logic               valid_i;
    logic               ready_o;
    logic [width_p-1:0] data_i;
    logic               valid_o;
    logic               ready_i;
    logic [width_p-1:0] data_o;
    logic [width_p-1:0] delayed_o;
    logic               primed_o;

    // Producer / consumer side (drives samples, accepts pairs).
    modport master (
        output flush_i, valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, delayed_o, primed_o
    );

    // Delay buffer side.
    modport slave (
        input  flush_i, valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, delayed_o, primed_o
    );
endinterface

// File: rtl/delay_buffer.sv
// Streaming sample delay line. Every accepted sample x[n] is emitted as a
// registered pair {x[n], x[n-depth_p]}; the delayed half reads as zero until
// depth_p samples have been seen since the last flush or reset.
module delay_buffer #(
    parameter int width_p = 16,
    parameter int depth_p = 16
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    delay_buffer_if.slave bus
);
    localparam int ptr_width_lp  = (depth_p == 1) ? 1 : $clog2(depth_p);
    localparam int fill_width_lp = $clog2(depth_p + 1);

    localparam logic [ptr_width_lp-1:0]  ptr_last_lp = ptr_width_lp'(depth_p - 1);
    localparam logic [fill_width_lp-1:0] fill_full_lp = fill_width_lp'(depth_p);

    logic [width_p-1:0]       mem [depth_p];
    logic [ptr_width_lp-1:0]  ptr_r;
    logic [fill_width_lp-1:0] fill_r;
    logic                     valid_r;
    logic [width_p-1:0]       data_r;
    logic [width_p-1:0]       delayed_r;

    logic                     primed;
    logic                     ready;
    logic                     accept;
    logic [width_p-1:0]       old_sample;

    assign primed     = (fill_r == fill_full_lp);
    assign ready      = !bus.flush_i && (!valid_r || bus.ready_i);
    assign accept     = bus.valid_i && ready;
    // Read-before-write: the slot about to be overwritten holds x[n-depth_p].
    assign old_sample = mem[ptr_r];

    // History storage: one write per accepted sample at the current pointer.
    // NOTE: the sample array is deliberately left out of reset; stale entries
    // are never observed because fill gates the delayed output.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem[ptr_r] <= bus.data_i;
        end
    end

    // Wrap-around pointer and saturating fill count.
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values, which the read-before-write relies on.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ptr_r  <= '0;
            fill_r <= '0;
        end else if (bus.flush_i) begin
            ptr_r  <= '0;
            fill_r <= '0;
        end else if (accept) begin
            ptr_r <= (ptr_r == ptr_last_lp) ? '0 : ptr_r + 1'b1;
            if (!primed) begin
                fill_r <= fill_r + 1'b1;
            end
        end
    end

    // Registered output pair with valid/ready handshake.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_r   <= 1'b0;
            data_r    <= '0;
            delayed_r <= '0;
        end else if (bus.flush_i) begin
            valid_r   <= 1'b0;
            data_r    <= '0;
            delayed_r <= '0;
        end else if (accept) begin
            valid_r   <= 1'b1;
            data_r    <= bus.data_i;
            delayed_r <= primed ? old_sample : '0;
        end else if (valid_r && bus.ready_i) begin
            valid_r <= 1'b0;
        end
    end

    assign bus.ready_o   = ready;
    assign bus.valid_o   = valid_r;
    assign bus.data_o    = data_r;
    assign bus.delayed_o = delayed_r;
    assign bus.primed_o  = primed;
endmodule
